// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall controller: the controller state
// encoding, the register-address width and the mult/div counter width.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int MD_CNT_W   = 6;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_MD_WAIT  = 2'd3
    } state_e;

endpackage

// File: rtl/load_use_cmp.sv
// -----------------------------------------------------------------------------
// load_use_cmp
// Combinational load-use hazard detector. Flags a hit when the instruction in
// EX is a load whose destination matches either source of the instruction in
// ID. Register 0 is hard-wired to zero and never creates a hazard.
// Ports:
//   mem_read  in  1           EX instruction is a load
//   ex_rt     in  REG_ADDR_W  EX destination register
//   id_rs     in  REG_ADDR_W  ID first source register
//   id_rt     in  REG_ADDR_W  ID second source register
//   hit       out 1           load-use hazard present
// -----------------------------------------------------------------------------
module load_use_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic                  mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    output logic                  hit
);

    logic rt_nonzero_s;
    logic addr_match_s;

    assign rt_nonzero_s = (ex_rt != {REG_ADDR_W{1'b0}});
    assign addr_match_s = (ex_rt == id_rs) || (ex_rt == id_rt);
    assign hit          = mem_read && rt_nonzero_s && addr_match_s;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Hazard and stall controller for a 5-stage pipeline. Resolves, in priority
// order, data-memory wait (full freeze), taken-branch flush, load-use stall
// and HI/LO wait on an in-flight multiply/divide. Control outputs are decoded
// combinationally from the current state and inputs.
//
// Optional feature: define PIPE_STALL_CNT_EN to add the stall_cycles counter
// port, which counts every cycle with pc_write low (wraps at 2^32).
//
// Parameters:
//   MD_LATENCY  mult/div occupancy in cycles, legal 2..63 (default 32)
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_id_rs, if_id_rt   in 5  ID source registers
//   id_ex_rt             in 5  EX destination register
//   id_ex_mem_read       in 1  EX instruction is a load
//   id_uses_hilo         in 1  ID instruction reads HI/LO or issues mult/div
//   md_start             in 1  mult/div enters EX this cycle (pulse)
//   branch_taken         in 1  EX resolved a taken branch/jump
//   dmem_req, dmem_ready in 1  MEM-stage request / completion
//   pc_write, if_id_write out  PC and IF/ID write enables
//   id_ex_bubble         out   zero the ID/EX controls
//   if_id_flush          out   clear IF/ID to NOP
//   pipe_freeze          out   hold ID/EX, EX/MEM, MEM/WB
//   md_busy              out   mult/div countdown active
//   stall_cycles         out32 stall counter (PIPE_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic                  id_ex_mem_read,
    input  logic                  id_uses_hilo,
    input  logic                  md_start,
    input  logic                  branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic                  pipe_freeze,
    output logic                  md_busy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    state_e                state_r;
    state_e                state_s;
    logic                  lu_hit_s;
    logic                  mem_wait_s;
    logic [MD_CNT_W-1:0]   md_cnt_r;
    logic                  md_busy_r;

    load_use_cmp u_load_use_cmp (
        .mem_read (id_ex_mem_read),
        .ex_rt    (id_ex_rt),
        .id_rs    (if_id_rs),
        .id_rt    (if_id_rt),
        .hit      (lu_hit_s)
    );

    assign mem_wait_s = dmem_req && !dmem_ready;
    assign md_busy    = md_busy_r;

    // Priority decode of control outputs and next state.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        pipe_freeze  = 1'b0;
        state_s      = state_r;
        if (!rst_n) begin
            // Outputs follow reset immediately, not only after the next edge.
            state_s = ST_RUN;
        end else if (mem_wait_s) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
            // A pending load-use or HI/LO stall survives the freeze.
            case (state_r)
                ST_LU_STALL: state_s = ST_LU_STALL;
                ST_MD_WAIT:  state_s = ST_MD_WAIT;
                default:     state_s = ST_MEM_WAIT;
            endcase
        end else if (branch_taken) begin
            // The ID instruction is squashed, so any stall it caused is moot.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_s      = ST_RUN;
        end else if (lu_hit_s && (state_r != ST_LU_STALL)) begin
            // LU_STALL marks the one cycle after a load-use stall, in which
            // the still-visible match must not stall a second time.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            state_s      = ST_LU_STALL;
        end else if (id_uses_hilo && md_busy_r) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            state_s      = ST_MD_WAIT;
        end else begin
            state_s = ST_RUN;
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Mult/div occupancy countdown; frozen cycles do not advance it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_r  <= {MD_CNT_W{1'b0}};
            md_busy_r <= 1'b0;
        end else if (md_start) begin
            md_cnt_r  <= MD_CNT_W'(MD_LATENCY - 1);
            md_busy_r <= 1'b1;
        end else if (md_busy_r && !pipe_freeze) begin
            if (md_cnt_r == {MD_CNT_W{1'b0}}) begin
                md_busy_r <= 1'b0;
            end else begin
                md_cnt_r <= md_cnt_r - {{(MD_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef PIPE_STALL_CNT_EN
    // Count every cycle in which the PC is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 32'd0;
        end else if (!pc_write) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;
    import pipe_ctrl_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic [REG_ADDR_W-1:0] if_id_rs;
    logic [REG_ADDR_W-1:0] if_id_rt;
    logic [REG_ADDR_W-1:0] id_ex_rt;
    logic                  id_ex_mem_read;
    logic                  id_uses_hilo;
    logic                  md_start;
    logic                  branch_taken;
    logic                  dmem_req;
    logic                  dmem_ready;
    logic                  pc_write;
    logic                  if_id_write;
    logic                  id_ex_bubble;
    logic                  if_id_flush;
    logic                  pipe_freeze;
    logic                  md_busy;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0]           stall_cycles;
`endif

    int n_cmp;
    int n_err;

    // {pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze, md_busy}
    logic [5:0] obs_v;
    assign obs_v = {pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze, md_busy};

    localparam logic [5:0] V_RUN   = 6'b110000;
    localparam logic [5:0] V_RUN_B = 6'b110001;
    localparam logic [5:0] V_LU    = 6'b001000;
    localparam logic [5:0] V_MD    = 6'b001001;
    localparam logic [5:0] V_BR    = 6'b111100;
    localparam logic [5:0] V_FRZ   = 6'b000010;
    localparam logic [5:0] V_FRZ_B = 6'b000011;

    pipe_stall_ctrl #(.MD_LATENCY(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .id_ex_rt       (id_ex_rt),
        .id_ex_mem_read (id_ex_mem_read),
        .id_uses_hilo   (id_uses_hilo),
        .md_start       (md_start),
        .branch_taken   (branch_taken),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .id_ex_bubble   (id_ex_bubble),
        .if_id_flush    (if_id_flush),
        .pipe_freeze    (pipe_freeze),
        .md_busy        (md_busy)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] exp);
        #1;
        n_cmp++;
        assert (obs_v === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs_v, exp);
        end
    endtask

    task automatic clear_inputs();
        if_id_rs       = 5'd0;
        if_id_rt       = 5'd0;
        id_ex_rt       = 5'd0;
        id_ex_mem_read = 1'b0;
        id_uses_hilo   = 1'b0;
        md_start       = 1'b0;
        branch_taken   = 1'b0;
        dmem_req       = 1'b0;
        dmem_ready     = 1'b0;
    endtask

    initial begin
        logic [5:0] exp_v;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        clear_inputs();

        // Reset: outputs fixed regardless of hazard inputs
        tick();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8;
        branch_taken = 1'b1; dmem_req = 1'b1; id_uses_hilo = 1'b1;
        chk("reset_out", V_RUN);
        clear_inputs();
        tick();
        rst_n = 1'b1;
        chk("post_reset", V_RUN);

        // Load-use on rs: exactly one stall cycle
        tick();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8; if_id_rt = 5'd3;
        chk("lu_stall", V_LU);
        tick();
        chk("lu_once", V_RUN);
        clear_inputs();
        tick();
        chk("lu_done", V_RUN);

        // Register 0 and non-matching cases never stall; rt match does
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0;
        chk("r0_nostall", V_RUN);
        tick();
        chk("r0_nostall2", V_RUN);
        id_ex_rt = 5'd5; if_id_rs = 5'd4; if_id_rt = 5'd6;
        chk("lu_nomatch", V_RUN);
        id_ex_mem_read = 1'b0; if_id_rt = 5'd5;
        chk("lu_noload", V_RUN);
        id_ex_mem_read = 1'b1;
        chk("lu_rt_match", V_LU);
        tick();
        clear_inputs();
        chk("lu_rt_rel", V_RUN);
        tick();

        // Branch overrides load-use and leaves no LU_STALL behind
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8; branch_taken = 1'b1;
        chk("br_over_lu", V_BR);
        tick();
        branch_taken = 1'b0;
        chk("br_then_lu", V_LU);
        clear_inputs();
        tick();
        chk("br_lu_rel", V_RUN);
        tick();

        // Memory wait beats branch and load-use; load-use follows the freeze
        dmem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8;
        chk("frz_over_br", V_FRZ);
        tick();
        branch_taken = 1'b0;
        chk("frz_hold", V_FRZ);
        tick();
        dmem_ready = 1'b1;
        chk("frz_rel_lu", V_LU);
        tick();
        clear_inputs();
        chk("frz_lu_once", V_RUN);
        tick();

        // Mult/div: busy for cycles 1..32 after md_start, HI/LO wait from cycle 2
        md_start = 1'b1;
        chk("md_start", V_RUN);
        for (int k = 1; k <= 33; k++) begin
            tick();
            md_start     = 1'b0;
            id_uses_hilo = (k >= 2);
            if (k == 1)       exp_v = V_RUN_B;
            else if (k <= 32) exp_v = V_MD;
            else              exp_v = V_RUN;
            chk($sformatf("md_wait_c%0d", k), exp_v);
        end
        clear_inputs();
        tick();

        // Freeze for cycles 5..7 delays the release by 3 cycles and holds MD_WAIT
        md_start = 1'b1;
        chk("mdf_start", V_RUN);
        for (int k = 1; k <= 36; k++) begin
            tick();
            md_start     = 1'b0;
            id_uses_hilo = (k >= 2);
            dmem_req     = (k >= 5) && (k <= 8);
            dmem_ready   = (k == 8);
            if (k == 1)                 exp_v = V_RUN_B;
            else if (k >= 5 && k <= 7)  exp_v = V_FRZ_B;
            else if (k <= 35)           exp_v = V_MD;
            else                        exp_v = V_RUN;
            chk($sformatf("mdf_c%0d", k), exp_v);
        end
        clear_inputs();
        tick();

        // Asynchronous reset in the middle of MD_WAIT
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        id_uses_hilo = 1'b1;
        tick();
        chk("rst_pre", V_MD);
        #2;
        rst_n = 1'b0;
        chk("rst_async", V_RUN);
`ifdef PIPE_STALL_CNT_EN
        n_cmp++;
        assert (stall_cycles === 32'd0) else begin
            n_err++;
            $error("FAIL rst_stall_cnt: observed %0d expected 0", stall_cycles);
        end
`endif
        tick();
        chk("rst_hold", V_RUN);
        rst_n = 1'b1;
        chk("rst_release", V_RUN);
        tick();
        chk("rst_no_residual", V_RUN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
